// File: rtl/booth_r4_seq_mult16.sv
// Sequential signed radix-4 Booth multiplier.
// Retires two multiplier bits per cycle, so a WIDTH x WIDTH product takes WIDTH/2 cycles.
// Operands arrive on a valid/ready stream and the product leaves on another one.
module booth_r4_seq_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic [2:0]           step_idx
);

  localparam int ITER  = WIDTH / 2;
  localparam int ACC_W = 2 * WIDTH;
  // The step counter also drives the partial-product shift, so it must reach ITER-1.
  localparam int SW    = (ITER > 8) ? $clog2(ITER) : 3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state;
  logic [WIDTH-1:0]  a_q;
  // Multiplier with the implicit b[-1]=0 appended; shifted right two bits per step so the
  // current Booth digit is always in the low three bits.
  logic [WIDTH:0]    b_q;
  logic [ACC_W-1:0]  acc_q;
  logic [SW-1:0]     step_q;

  logic [WIDTH+1:0]  a_ext;
  logic [WIDTH+1:0]  pp_small;
  logic [2:0]        digit;
  logic [ACC_W-1:0]  pp_ext;
  logic [ACC_W-1:0]  pp_shift;
  logic [ACC_W-1:0]  acc_next;
  logic              last_step;

  assign step_idx = step_q[2:0];

  // Select d*A for the current digit, widen it and align it to bit position 2*step.
  always_comb begin
    a_ext    = {{2{a_q[WIDTH-1]}}, a_q};
    digit    = b_q[2:0];
    pp_small = '0;
    unique case (digit)
      3'b000, 3'b111: pp_small = '0;
      3'b001, 3'b010: pp_small = a_ext;
      3'b011:         pp_small = a_ext << 1;
      3'b100:         pp_small = -(a_ext << 1);
      3'b101, 3'b110: pp_small = -a_ext;
      default:        pp_small = '0;
    endcase
    pp_ext    = {{(ACC_W-WIDTH-2){pp_small[WIDTH+1]}}, pp_small};
    pp_shift  = pp_ext << {step_q, 1'b0};
    acc_next  = acc_q + pp_shift;
    last_step = (step_q == SW'(ITER - 1));
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      P         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      step_q    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= {B, 1'b0};
            acc_q    <= '0;
            step_q   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          b_q   <= {2'b00, b_q[WIDTH:2]};
          if (last_step) begin
            P         <= acc_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            step_q    <= '0;
            state     <= StDone;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult16.sv
// Scoreboard bench for the sequential radix-4 Booth multiplier.
module tb_booth_r4_seq_mult16;

  localparam int WIDTH = 16;
  localparam int ITER  = WIDTH / 2;
  localparam int NRAND = 3000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   A = '0;
  logic [WIDTH-1:0]   B = '0;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] P;
  logic               busy;
  logic [2:0]         step_idx;

  booth_r4_seq_mult16 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .busy      (busy),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*WIDTH-1:0] p;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   sent_cnt = 0;
  int   done_cnt = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout (t=%0t)", name, $time);
  endtask

  // Reference: plain signed multiply at product width.
  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0]   sa;
    logic signed [WIDTH-1:0]   sb;
    logic signed [2*WIDTH-1:0] r;
    sa = a;
    sb = b;
    r  = sa * sb;
    return r;
  endfunction

  // Downstream ready generator; changes only just after a rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: checks latency on each out_valid rise and pops on each product handshake.
  initial begin
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && !prev_ov) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'd0);
          end else begin
            chk("latency", 64'(cyc - q[0].cyc), 64'(ITER + 1));
          end
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_product", 64'(out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            chk("product", 64'(P), 64'(e.p));
            done_cnt++;
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  // Present one operand pair, hold until accepted, then scramble the bus.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    A = a;
    B = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        timeout_fail("accept");
        break;
      end
    end
    e.p   = model(a, b);
    e.cyc = cyc;
    q.push_back(e);
    sent_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 50) begin
        timeout_fail("wait_out_valid");
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        timeout_fail("drain");
        q.delete();
      end
    end
  endtask

  task automatic directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] p_req, input string name);
    send(a, b);
    wait_out();
    chk(name, 64'(P), 64'(p_req));
    wait_drain();
  endtask

  initial begin
    logic [2*WIDTH-1:0] hold_p;
    int                 n;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_P", 64'(P), 64'd0);
    chk("rst_step_idx", 64'(step_idx), 64'd0);
    rst = 1'b0;

    // Basic product and RUN status.
    send(16'd3, 16'd5);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    wait_out();
    chk("p_3x5", 64'(P), 64'h0000_000F);
    wait_drain();

    directed(16'h8000, 16'h8000, 32'h4000_0000, "p_min_x_min");
    directed(16'h7FFF, 16'h8000, 32'hC000_8000, "p_max_x_min");
    directed(16'hFFFF, 16'h0001, 32'hFFFF_FFFF, "p_m1_x_1");

    // Backpressure: hold the product for 20 cycles.
    rdy_mode = 0;
    send(16'hFFFB, 16'd1234);
    hold_p = model(16'hFFFB, 16'd1234);
    wait_out();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_P", 64'(P), 64'(hold_p));
    end
    rdy_mode = 1;
    wait_drain();
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a product.
    send(16'd1000, 16'd2000);
    n = 0;
    while (step_idx != 3'd4) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 20) begin
        timeout_fail("wait_step4");
        break;
      end
    end
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_P", 64'(P), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_step_idx", 64'(step_idx), 64'd0);
    directed(16'd7, 16'hFFF7, 32'hFFFF_FFC1, "p_7_x_m9");

    // Random operands with random stalls on both sides.
    rdy_mode = 2;
    sent_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < NRAND; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'hFFFF;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(ra, rb);
    end
    wait_drain();
    repeat (4) @(negedge clk);
    chk("rand_count", 64'(done_cnt), 64'(sent_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
